debug: RTL and testbench



---
 rtl/debug.sv | 164 ++++++++++++++++
 tb/tb_debug.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/debug.sv
// Logic-analyzer capture buffer with a JTAG user-scan readout port.
// Scan frames carry a 16-bit address then streamed 16-bit data words.
module debug #(
  parameter int N     = 32,
  parameter int DEPTH = 64,
  parameter int PRE   = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         trigger,
  input  logic [N-1:0] indata,
  input  logic         capture,
  input  logic         shift,
  input  logic         drck,
  input  logic         tdi,
  output logic         tdo
);

  localparam int SL   = N / 16;
  localparam int BUFW = DEPTH * SL;
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {PH_ADDR, PH_DATA} phase_e;

  phase_e        phase_q, phase_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          drck_q;
  logic          armed_q, armed_d;
  logic          trig_q, trig_d;
  logic          done_q, done_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rem_q, rem_d, rem_nxt;

  logic [N-1:0]  mem [DEPTH];

  logic          bit_edge, arm, wr_en;
  logic [15:0]   rd_addr, rd_word;
  logic [31:0]   samp, slc;
  logic [AW-1:0] ridx;
  logic [N-1:0]  row;

  assign bit_edge = drck & ~drck_q;
  assign arm = bit_edge & ~capture & shift & (phase_q == PH_DATA) &
               (cnt_q == 4'd15) & (addr_q == 16'hFF01);
  assign wr_en = armed_q & ~arm & ~reset;

  // Completed address on the last ADDR edge, next word on the last DATA edge.
  assign rd_addr = (phase_q == PH_ADDR) ? ((addr_q << 1) | {15'd0, tdi})
                                        : (addr_q + 16'd1);

  always_comb begin
    rd_word = '0;
    samp    = '0;
    slc     = '0;
    ridx    = '0;
    row     = '0;
    if (32'(rd_addr) < 32'(BUFW)) begin
      samp    = 32'(rd_addr) / 32'(SL);
      slc     = 32'(rd_addr) % 32'(SL);
      ridx    = AW'(samp) + wptr_q;
      row     = mem[ridx];
      rd_word = 16'(row >> (32'(N) - 32'd16 - (slc << 4)));
    end else if (rd_addr[15:8] == 8'hFF) begin
      case (rd_addr[7:0])
        8'h00:   rd_word = {13'd0, done_q, trig_q, armed_q};
        8'h02:   rd_word = 16'(N);
        8'h03:   rd_word = 16'(DEPTH);
        default: rd_word = '0;
      endcase
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    armed_d = armed_q;
    trig_d  = trig_q;
    done_d  = done_q;
    wptr_d  = wptr_q;
    rem_d   = rem_q;
    rem_nxt = rem_q;
    if (bit_edge) begin
      if (capture) begin
        cnt_d   = '0;
        phase_d = PH_ADDR;
      end else if (shift) begin
        cnt_d = cnt_q + 4'd1;
        if (phase_q == PH_ADDR) begin
          addr_d = (addr_q << 1) | {15'd0, tdi};
          if (cnt_q == 4'd15) begin
            phase_d = PH_DATA;
            rdata_d = rd_word;
          end
        end else begin
          wdata_d = (wdata_q << 1) | {15'd0, tdi};
          if (cnt_q == 4'd15) begin
            addr_d  = addr_q + 16'd1;
            rdata_d = rd_word;
          end
        end
      end
    end
    // rem counts writes still due after the current one, so the trigger
    // sample plus DEPTH-PRE-1 followers land with the trigger at index PRE.
    if (arm) begin
      armed_d = 1'b1;
      trig_d  = 1'b0;
      done_d  = 1'b0;
      wptr_d  = '0;
    end else if (armed_q) begin
      wptr_d = wptr_q + 1'b1;
      if (trig_q || trigger) begin
        rem_nxt = trig_q ? (rem_q - 1'b1) : AW'(DEPTH - PRE - 1);
        rem_d   = rem_nxt;
        trig_d  = 1'b1;
        if (rem_nxt == '0) begin
          done_d  = 1'b1;
          armed_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= PH_ADDR;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      drck_q  <= 1'b0;
      armed_q <= 1'b0;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
      wptr_q  <= '0;
      rem_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      drck_q  <= drck;
      armed_q <= armed_d;
      trig_q  <= trig_d;
      done_q  <= done_d;
      wptr_q  <= wptr_d;
      rem_q   <= rem_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q] <= indata;
  end

  assign tdo = (phase_q == PH_DATA) ? rdata_q[4'd15 - cnt_q] : 1'b0;

endmodule

// File: tb/tb_debug.sv
// Directed bench for the debug capture block: arm, trigger, scan readout,
// streaming, identity/hole reads and reset behaviour.
module tb_debug;
  logic        clk = 1'b0;
  logic        reset, trigger, capture, shift, drck, tdi, tdo;
  logic [31:0] indata = 32'h0;
  logic        tog = 1'b0;
  int          checks = 0, failures = 0;

  debug #(.N(32), .DEPTH(64), .PRE(16)) dut (
    .clk(clk), .reset(reset), .trigger(trigger), .indata(indata),
    .capture(capture), .shift(shift), .drck(drck), .tdi(tdi), .tdo(tdo)
  );

  always #5 clk = ~clk;

  // Probe bus alternates every clk between two fixed patterns.
  always @(negedge clk) begin
    tog = ~tog;
    indata = tog ? 32'hDEADBEEF : 32'hCAFEBABE;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One drck bit: low for a clk, then rise with inputs held; tdo sampled before the rise.
  task automatic drbit(input logic c, input logic s, input logic t, output logic o);
    @(negedge clk);
    drck = 1'b0; capture = c; shift = s; tdi = t;
    @(negedge clk);
    o = tdo;
    drck = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic shword(input logic [15:0] wd, output logic [15:0] rd);
    logic o;
    rd = '0;
    for (int i = 0; i < 16; i++) begin
      drbit(1'b0, 1'b1, wd[15-i], o);
      rd = {rd[14:0], o};
    end
  endtask

  task automatic frame(input logic [15:0] a, input logic [15:0] wd,
                       output logic [15:0] rd, output logic tdo_first);
    logic o;
    drbit(1'b1, 1'b0, 1'b0, o);
    tdo_first = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drbit(1'b0, 1'b1, a[15-i], o);
      if (i == 0) tdo_first = o;
    end
    shword(wd, rd);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1; drck = 1'b0; capture = 1'b0; shift = 1'b0; tdi = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  logic [15:0] rd;
  logic        t0, o;
  logic [31:0] v, w, s;
  int          sidx;

  initial begin
    reset = 1'b1; trigger = 1'b0; capture = 1'b0; shift = 1'b0;
    drck = 1'b0; tdi = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tdo", {31'd0, tdo}, 32'd0);
    reset = 1'b0;

    frame(16'hFF00, 16'h0, rd, t0);
    chk("reset_status", {16'd0, rd}, 32'h0000);

    frame(16'hFF01, 16'h0, rd, t0);
    chk("capture_tdo0", {31'd0, t0}, 32'd0);
    frame(16'hFF00, 16'h0, rd, t0);
    chk("armed_status", {16'd0, rd}, 32'h0001);

    @(negedge clk);
    trigger = 1'b1;
    #1 v = indata;
    w = (v == 32'hDEADBEEF) ? 32'hCAFEBABE : 32'hDEADBEEF;
    repeat (34) @(negedge clk);
    trigger = 1'b0;
    repeat (20) @(negedge clk);
    frame(16'hFF00, 16'h0, rd, t0);
    chk("done_status", {16'd0, rd}, 32'h0006);

    // Sample 0 is PRE (even) samples before the trigger, so it matches it.
    frame(16'h0000, 16'h0, rd, t0);
    chk("word0", {16'd0, rd}, {16'd0, v[31:16]});
    shword(16'h0, rd);
    chk("word1", {16'd0, rd}, {16'd0, v[15:0]});

    // Stream words 30..37: samples 15..18 around the trigger at sample 16.
    frame(16'd30, 16'h0, rd, t0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) shword(16'h0, rd);
      sidx = 15 + i / 2;
      s = (sidx % 2 == 0) ? v : w;
      chk($sformatf("stream_w%0d", 30 + i), {16'd0, rd},
          {16'd0, (i % 2 == 0) ? s[31:16] : s[15:0]});
    end

    frame(16'hFF02, 16'h0, rd, t0);
    chk("id_n", {16'd0, rd}, 32'h0020);
    frame(16'hFF03, 16'h0, rd, t0);
    chk("id_depth", {16'd0, rd}, 32'h0040);
    frame(16'h0100, 16'h0, rd, t0);
    chk("hole_0100", {16'd0, rd}, 32'h0000);
    frame(16'hFF10, 16'h0, rd, t0);
    chk("hole_ff10", {16'd0, rd}, 32'h0000);

    // Reset during capture.
    frame(16'hFF01, 16'h1234, rd, t0);
    repeat (10) @(negedge clk);
    pulse_reset();
    chk("rst_cap_tdo", {31'd0, tdo}, 32'd0);
    reset = 1'b0;
    frame(16'hFF00, 16'h0, rd, t0);
    chk("rst_cap_status", {16'd0, rd}, 32'h0000);

    // Reset mid-frame to the arm register: no arm must happen.
    drbit(1'b1, 1'b0, 1'b0, o);
    for (int i = 0; i < 16; i++) drbit(1'b0, 1'b1, 1'(16'hFF01 >> (15 - i)), o);
    for (int i = 0; i < 10; i++) drbit(1'b0, 1'b1, 1'b1, o);
    pulse_reset();
    chk("rst_frame_tdo", {31'd0, tdo}, 32'd0);
    reset = 1'b0;
    frame(16'hFF00, 16'h0, rd, t0);
    chk("rst_frame_status", {16'd0, rd}, 32'h0000);
    frame(16'hFF03, 16'h0, rd, t0);
    chk("post_rst_decode", {16'd0, rd}, 32'h0040);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
